// File: rtl/multicycle_control_unit_if.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control_unit_if
// Purpose  : Handshake and control bundle between the instruction source and
//            the multi-cycle control unit, plus the datapath control outputs.
// Ports    : master - instruction source / memory side (drives InputBits,
//                     InstrValid, MemReady; observes all control outputs)
//            slave  - control unit (consumes the inputs, drives the outputs)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_unit_if #(
  parameter int INSTR_WIDTH = 8,
  parameter int ALUOP_WIDTH = 2
);
  logic [INSTR_WIDTH-1:0] InputBits;
  logic                   InstrValid;
  logic                   InstrReady;
  logic                   MemReady;
  logic                   RegWrite;
  logic [ALUOP_WIDTH-1:0] ALUop;
  logic                   ALUsrc;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   MemToReg;
  logic                   IRWrite;
  logic                   PCWrite;
  logic                   Busy;
  logic                   IllegalOp;
  logic                   MemError;

  modport master (
    output InputBits, InstrValid, MemReady,
    input  InstrReady, RegWrite, ALUop, ALUsrc, MemRead, MemWrite, MemToReg,
           IRWrite, PCWrite, Busy, IllegalOp, MemError
  );

  modport slave (
    input  InputBits, InstrValid, MemReady,
    output InstrReady, RegWrite, ALUop, ALUsrc, MemRead, MemWrite, MemToReg,
           IRWrite, PCWrite, Busy, IllegalOp, MemError
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control_unit
// Purpose  : Multi-cycle control FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK) for
//            the 8-bit datapath. Accepts an instruction over a valid/ready
//            handshake, waits on MemReady with a bounded timeout, and flags
//            illegal opcodes and memory timeouts.
// Ports    : clk   - clock, all state changes on the rising edge
//            reset - synchronous active-high reset
//            bus   - multicycle_control_unit_if.slave (handshake + controls)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
  parameter int INSTR_WIDTH  = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int ALUOP_WIDTH  = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  multicycle_control_unit_if.slave   bus
);

  localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MEM_TIMEOUT);

  localparam logic [OPCODE_WIDTH-1:0] c_OP_ADD  = OPCODE_WIDTH'(3'b000);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_ADDI = OPCODE_WIDTH'(3'b100);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_SW   = OPCODE_WIDTH'(3'b101);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_LW   = OPCODE_WIDTH'(3'b110);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_SLL  = OPCODE_WIDTH'(3'b111);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  state_t                  r_state;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [c_CNT_W-1:0]      r_cnt;

  logic w_legal;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_mem;
  logic w_is_sll;
  logic w_alusrc_op;
  logic w_timeout;

  // Only the opcode field of the instruction word matters to this unit.
  wire w_unused_bits = &{1'b0, bus.InputBits};

  assign w_is_lw     = (r_opcode == c_OP_LW);
  assign w_is_sw     = (r_opcode == c_OP_SW);
  assign w_is_sll    = (r_opcode == c_OP_SLL);
  assign w_is_mem    = w_is_lw | w_is_sw;
  assign w_legal     = (r_opcode == c_OP_ADD) | (r_opcode == c_OP_ADDI) | w_is_mem | w_is_sll;
  assign w_alusrc_op = w_legal & (r_opcode != c_OP_ADD);
  // Last permitted MEM cycle without a MemReady.
  assign w_timeout   = (r_cnt == c_CNT_LAST) & ~bus.MemReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.InstrValid) begin
            r_opcode <= bus.InputBits[INSTR_WIDTH-1 -: OPCODE_WIDTH];
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= w_legal ? S_EXECUTE : S_FETCH;
        end
        S_EXECUTE: begin
          r_cnt   <= '0;
          r_state <= w_is_mem ? S_MEM : S_WRITEBACK;
        end
        S_MEM: begin
          if (bus.MemReady) begin
            r_state <= w_is_lw ? S_WRITEBACK : S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_FETCH;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITEBACK: begin
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Control outputs are a pure decode of the state and the latched opcode so
  // that a zero-wait MemReady and the IR load act within the same cycle.
  always_comb begin
    bus.InstrReady = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUop      = '0;
    bus.ALUsrc     = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.MemToReg   = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.IllegalOp  = 1'b0;
    bus.MemError   = 1'b0;
    bus.Busy       = (r_state != S_FETCH);
    case (r_state)
      S_FETCH: begin
        bus.InstrReady = 1'b1;
        bus.IRWrite    = bus.InstrValid;
      end
      S_DECODE: begin
        bus.ALUsrc    = w_alusrc_op;
        bus.IllegalOp = ~w_legal;
      end
      S_EXECUTE: begin
        bus.ALUsrc = w_alusrc_op;
        bus.ALUop  = w_is_sll ? ALUOP_WIDTH'(1) : '0;
      end
      S_MEM: begin
        bus.ALUsrc   = 1'b1;
        bus.MemRead  = w_is_lw;
        bus.MemToReg = w_is_lw;
        bus.MemWrite = w_is_sw;
        bus.PCWrite  = w_is_sw & bus.MemReady;
        bus.MemError = w_timeout;
      end
      S_WRITEBACK: begin
        bus.RegWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.MemToReg = w_is_lw;
      end
      default: begin
        bus.Busy = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle decoder. It latches an instruction through a valid/ready handshake and sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK states.
- Drives datapath control signals per state, including PC/IR write enables.
- Waits on a memory ready handshake, bounded by a timeout; flags illegal opcodes and memory timeouts.
- Sits between the instruction source and the 8-bit datapath (register file, ALU, data memory).

Parameters:
- INSTR_WIDTH, 8, instruction word width.
- OPCODE_WIDTH, 3, opcode field width; the field is InputBits[INSTR_WIDTH-1 -: OPCODE_WIDTH].
- ALUOP_WIDTH, 2, width of ALUop.
- MEM_TIMEOUT, 15, maximum cycles in MEM without MemReady before abort (>=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous active-high reset.
- InputBits  in  INSTR_WIDTH  instruction word from the fetch source.
- InstrValid  in  1  InputBits holds a valid instruction.
- InstrReady  out  1  unit can accept an instruction (FETCH only).
- MemReady  in  1  data memory completed the current access.
- RegWrite  out  1  register file write enable.
- ALUop  out  ALUOP_WIDTH  00 add, 01 shift-left-logical; others reserved.
- ALUsrc  out  1  1 selects the immediate as the ALU B operand.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- MemToReg  out  1  1 selects memory data for register writeback.
- IRWrite  out  1  instruction register load enable.
- PCWrite  out  1  PC increment enable; one-cycle retire pulse.
- Busy  out  1  high in any state other than FETCH.
- IllegalOp  out  1  one-cycle pulse, undefined opcode.
- MemError  out  1  one-cycle pulse, memory timeout.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state <= FETCH; opcode register <= 0; timeout counter <= 0.
  - All outputs 0 except InstrReady=1.
  - Reset overrides every state, including mid-MEM.
- Outputs are decoded combinationally from state plus the latched opcode register only, never from live InputBits after acceptance. Unlisted outputs are 0 in each state.
- FETCH:
  - InstrReady=1; IRWrite=InstrValid.
  - On InstrValid=1: latch opcode, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Legal opcodes are 000 add, 100 addi, 101 sw, 110 lw, 111 sll; ALUsrc is valid for the latched opcode.
  - Illegal opcode (001, 010, 011): IllegalOp=1 this cycle, no PCWrite, go to FETCH.
  - Legal opcode: go to EXECUTE.
- EXECUTE (1 cycle):
  - ALUsrc=1 for addi/sw/lw/sll; 0 for add.
  - ALUop=01 for sll; 00 otherwise.
  - add/addi/sll go to WRITEBACK; lw/sw go to MEM with the counter cleared.
- MEM:
  - ALUsrc=1, ALUop=00 held.
  - lw: MemRead=1, MemToReg=1. sw: MemWrite=1.
  - The request is held every cycle until MemReady=1. MemReady sampled in the same cycle as the request counts; zero wait is legal.
  - On MemReady: lw goes to WRITEBACK; sw asserts PCWrite=1 and goes to FETCH.
  - On no MemReady: counter increments. When the counter equals MEM_TIMEOUT-1 and MemReady=0: MemError=1, requests drop next cycle, go to FETCH, no PCWrite.
  - MemReady in the timeout cycle wins over MemError.
- WRITEBACK (1 cycle):
  - RegWrite=1, PCWrite=1, go to FETCH.
  - MemToReg=1 for lw; 0 otherwise.
  - sw never reaches WRITEBACK and never asserts RegWrite.
- Latency from accept edge to next InstrReady:
  - add/addi/sll: 3 cycles.
  - lw: 4+N cycles (N = MemReady wait cycles).
  - sw: 3+N cycles.
- Illegal op: 1 cycle.
- InstrValid outside FETCH is ignored; InputBits changes after acceptance do not affect the outputs.
- MemReady outside MEM is ignored.
- Never assert both MemRead and MemWrite.
- Never assert RegWrite together with MemWrite.
- Counter width is $clog2(MEM_TIMEOUT+1); it saturates, with no wrap.

Test Plan:
- Reset mid-MEM:
  - Stimulus: lw 0xC3 accepted, MemReady held 0 for 2 cycles, then reset=1 for 1 cycle.
  - Required: next cycle is FETCH, InstrReady=1, all other outputs 0, no MemError or PCWrite.
- add then addi back-to-back:
  - Stimulus: InputBits=0x05 (add) then 0x85 (addi), InstrValid held 1.
  - Required: DECODE/EXECUTE/WB per instruction; RegWrite pulses once each, 3 cycles after each accept; ALUsrc=0 for add and 1 for addi in EXECUTE; PCWrite=1 with each RegWrite.
- lw with 2-cycle wait:
  - Stimulus: 0xC1; MemReady=1 on the third MEM cycle.
  - Required: MemRead=1 for exactly 3 cycles; WB has RegWrite=1, MemToReg=1, PCWrite=1; total 6 cycles accept-to-InstrReady.
- sw zero-wait:
  - Stimulus: 0xA2; MemReady=1 in the first MEM cycle.
  - Required: MemWrite=1 for 1 cycle with PCWrite=1 in that cycle; RegWrite never 1; back to FETCH.
- Illegal op and sll:
  - Stimulus: 0x40 (opcode 010), then 0xE3 (sll).
  - Required: IllegalOp=1 one cycle in DECODE, no PCWrite; sll EXECUTE shows ALUop=01, ALUsrc=1, then RegWrite=1.
- Timeout with MEM_TIMEOUT=4:
  - Stimulus: lw, MemReady=0 throughout.
  - Required: MemRead=1 for 4 cycles, MemError=1 in the 4th, FETCH next, no RegWrite.
  - Repeat with MemReady=1 in the 4th cycle: no MemError, normal WB.
